// File: rtl/ram_loader.sv
// -----------------------------------------------------------------------------
// ram_loader
//
// Byte-stream boot loader placed in front of the system RAM write port.
// A framed byte stream from the serial receiver is parsed, bytes are paired
// into 16-bit little-endian words and written to consecutive RAM addresses.
// While no frame is in progress the CPU's RAM request passes straight through.
//
// Frame: SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, CNT x (DATA_LO, DATA_HI), CSUM
// The 8-bit sum of every byte after SYNC, CSUM included, must be zero.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx_data      received byte
//   rx_valid     rx_data valid
//   rx_ready     loader can take a byte (low only in the RAM write cycle)
//   cpu_din      CPU write data
//   cpu_address  CPU word address
//   cpu_rnw      CPU read(1) / write(0)
//   cpu_cs_b     CPU RAM select, active low
//   ram_din      RAM write data
//   ram_address  RAM word address
//   ram_rnw      RAM read(1) / write(0)
//   ram_cs_b     RAM select, active low
//   loading      a frame is in progress; the CPU is held off
//   done         one-cycle pulse when a frame ends with a good checksum
//   error        sticky; set on bad checksum or oversize count, cleared by
//                the next accepted SYNC byte
// -----------------------------------------------------------------------------
module ram_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [15:0]       cpu_din,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_rnw,
  input  logic              cpu_cs_b,
  output logic [15:0]       ram_din,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rnw,
  output logic              ram_cs_b,
  output logic              loading,
  output logic              done,
  output logic              error
);

  // A count may be anything from 0 up to the full RAM depth, so the word
  // counter needs one bit more than the address.
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam logic [16:0] MAX_CNT = 17'(1 << ADDR_W);

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_LO,
    S_A_HI,
    S_C_LO,
    S_C_HI,
    S_D_LO,
    S_D_HI,
    S_WR,
    S_CSUM
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;        // next RAM word address to write
  logic [CNT_W-1:0]  remaining;  // words still to be written in this frame
  logic [7:0]        sum;        // running 8-bit sum of bytes after SYNC
  logic [7:0]        lo_byte;    // low half of address / count / data word
  logic [7:0]        hi_byte;    // high half of the data word

  logic              take;       // byte transfer happens at this edge
  logic [15:0]       pair;       // current byte joined with the held low byte
  logic [16:0]       cnt_ext;    // count widened for the oversize compare
  logic [7:0]        sum_next;   // running sum including the current byte

  assign take     = rx_valid & rx_ready;
  assign pair     = {rx_data, lo_byte};
  assign cnt_ext  = {1'b0, pair};
  assign sum_next = sum + rx_data;

  // ---------------------------------------------------------------------------
  // Frame parser. rx_ready, loading, done and error are all flops updated
  // alongside the state so that they change on the same edge as the state.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values together; a blocking = would let later statements see
  // the freshly updated value and silently change the logic.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      sum       <= '0;
      lo_byte   <= '0;
      hi_byte   <= '0;
      rx_ready  <= 1'b1;
      loading   <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Anything other than SYNC is dropped on the floor.
          if (take && rx_data == SYNC_BYTE) begin
            sum     <= '0;
            error   <= 1'b0;
            loading <= 1'b1;
            state   <= S_A_LO;
          end
        end

        S_A_LO: begin
          if (take) begin
            lo_byte <= rx_data;
            sum     <= sum_next;
            state   <= S_A_HI;
          end
        end

        S_A_HI: begin
          if (take) begin
            // Address bits above the RAM depth are ignored.
            ptr   <= pair[ADDR_W-1:0];
            sum   <= sum_next;
            state <= S_C_LO;
          end
        end

        S_C_LO: begin
          if (take) begin
            lo_byte <= rx_data;
            sum     <= sum_next;
            state   <= S_C_HI;
          end
        end

        S_C_HI: begin
          if (take) begin
            sum <= sum_next;
            if (cnt_ext > MAX_CNT) begin
              // More words than the RAM holds: abandon the frame at once.
              error   <= 1'b1;
              loading <= 1'b0;
              state   <= S_IDLE;
            end else if (pair == 16'h0000) begin
              state <= S_CSUM;
            end else begin
              remaining <= pair[CNT_W-1:0];
              state     <= S_D_LO;
            end
          end
        end

        S_D_LO: begin
          if (take) begin
            lo_byte <= rx_data;
            sum     <= sum_next;
            state   <= S_D_HI;
          end
        end

        S_D_HI: begin
          if (take) begin
            hi_byte  <= rx_data;
            sum      <= sum_next;
            rx_ready <= 1'b0;
            state    <= S_WR;
          end
        end

        S_WR: begin
          // The RAM captures the word at the edge that ends this cycle.
          ptr       <= ptr + 1'b1;
          remaining <= remaining - 1'b1;
          rx_ready  <= 1'b1;
          state     <= (remaining == CNT_W'(1)) ? S_CSUM : S_D_LO;
        end

        S_CSUM: begin
          if (take) begin
            if (sum_next == 8'h00) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
            loading <= 1'b0;
            state   <= S_IDLE;
          end
        end

        default: begin
          rx_ready <= 1'b1;
          loading  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port mux. Reset wins over everything so that a write cycle in flight
  // when reset arrives never reaches the RAM.
  // ---------------------------------------------------------------------------
  // NOTE: each output gets a default before any branch; without it a path
  // that skips an assignment would make the tool infer a latch.
  always_comb begin
    ram_din     = '0;
    ram_address = '0;
    ram_rnw     = 1'b1;
    ram_cs_b    = 1'b1;
    if (!reset) begin
      if (!loading) begin
        ram_din     = cpu_din;
        ram_address = cpu_address;
        ram_rnw     = cpu_rnw;
        ram_cs_b    = cpu_cs_b;
      end else begin
        ram_din     = {hi_byte, lo_byte};
        ram_address = ptr;
        if (state == S_WR) begin
          ram_rnw  = 1'b0;
          ram_cs_b = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_ram_loader
//
// Directed bench for ram_loader. Each frame is handed to a frame-level model
// that works out, from the frame rules alone, which RAM words must be written
// and whether the frame ends in done or error. A compare process checks the
// RAM port every cycle against that expectation and against the CPU
// pass-through; directed checks pin timing points and literal results.
// -----------------------------------------------------------------------------
module tb_ram_loader;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [15:0]   cpu_din;
  logic [AW-1:0] cpu_address;
  logic          cpu_rnw;
  logic          cpu_cs_b;
  logic [15:0]   ram_din;
  logic [AW-1:0] ram_address;
  logic          ram_rnw;
  logic          ram_cs_b;
  logic          loading;
  logic          done;
  logic          error;

  ram_loader #(.ADDR_W(AW), .SYNC_BYTE(8'h55)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .cpu_din     (cpu_din),
    .cpu_address (cpu_address),
    .cpu_rnw     (cpu_rnw),
    .cpu_cs_b    (cpu_cs_b),
    .ram_din     (ram_din),
    .ram_address (ram_address),
    .ram_rnw     (ram_rnw),
    .ram_cs_b    (ram_cs_b),
    .loading     (loading),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total    = 0;
  int  bad      = 0;
  int  done_exp = 0;
  int  done_seen = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: expected writes go onto exp_q.
  task automatic model_frame(input bq_t f, output logic ed, output logic ee, output int cnt);
    int         base;
    logic [7:0] s;
    base = (int'(f[1]) + 256 * int'(f[2])) % DEPTH;
    cnt  = int'(f[3]) + 256 * int'(f[4]);
    ed   = 1'b0;
    ee   = 1'b1;
    if (cnt <= DEPTH) begin
      for (int k = 0; k < cnt; k++) begin
        wr_t w;
        w.a = AW'((base + k) % DEPTH);
        w.d = {f[6 + 2 * k], f[5 + 2 * k]};
        exp_q.push_back(w);
      end
      s = 8'h00;
      for (int j = 1; j < f.size(); j++) s = s + f[j];
      ed = (s == 8'h00);
      ee = ~ed;
    end
  endtask

  function automatic logic [7:0] csum_of(input bq_t f);
    logic [7:0] s;
    s = 8'h00;
    for (int j = 1; j < f.size(); j++) s = s + f[j];
    return 8'h00 - s;
  endfunction

  // Called at a negedge; returns at the negedge after the byte is taken.
  // rx_valid is left high so consecutive bytes stream back to back.
  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (!rx_ready) begin
      check("byte_accept_timeout", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input bq_t f);
    logic ed, ee;
    int   cnt;
    model_frame(f, ed, ee, cnt);
    if (ed) done_exp++;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i]);
      if (i == 0) begin
        check("sync_clears_error", 32'(error), 32'd0);
        check("sync_sets_loading", 32'(loading), 32'd1);
      end
      if (cnt > DEPTH) begin
        if (i == 4) begin
          check("oversize_error", 32'(error), 32'd1);
          check("oversize_loading", 32'(loading), 32'd0);
        end
      end else begin
        if (i >= 6 && i < 5 + 2 * cnt && ((i - 6) % 2) == 0) begin
          check("write_after_data_hi", 32'(ram_cs_b), 32'd0);
        end
        if (i == f.size() - 1) begin
          check("frame_end_done", 32'(done), 32'(ed));
          check("frame_end_error", 32'(error), 32'(ee));
          check("frame_end_loading", 32'(loading), 32'd0);
        end
      end
    end
    rx_valid = 1'b0;
    if (cnt <= DEPTH) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic cpu_set(input logic [AW-1:0] a, input logic [15:0] d,
                         input logic rnw, input logic cs_b);
    @(posedge clk);
    #2;
    cpu_address = a;
    cpu_din     = d;
    cpu_rnw     = rnw;
    cpu_cs_b    = cs_b;
    @(negedge clk);
  endtask

  // Every-cycle comparison of the RAM port and handshake.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_ram_cs_b", 32'(ram_cs_b), 32'd1);
      check("rst_ram_rnw", 32'(ram_rnw), 32'd1);
      check("rst_ram_address", 32'(ram_address), 32'd0);
      check("rst_ram_din", 32'(ram_din), 32'd0);
    end else if (!loading) begin
      check("pass_din", 32'(ram_din), 32'(cpu_din));
      check("pass_address", 32'(ram_address), 32'(cpu_address));
      check("pass_rnw", 32'(ram_rnw), 32'(cpu_rnw));
      check("pass_cs_b", 32'(ram_cs_b), 32'(cpu_cs_b));
      check("idle_rx_ready", 32'(rx_ready), 32'd1);
    end else if (!ram_cs_b) begin
      check("wr_rnw", 32'(ram_rnw), 32'd0);
      check("wr_rx_ready", 32'(rx_ready), 32'd0);
      obs_q.push_back('{a: ram_address, d: ram_din});
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_address", 32'(ram_address), 32'(w.a));
        check("wr_data", 32'(ram_din), 32'(w.d));
      end
    end else begin
      check("load_ram_rnw", 32'(ram_rnw), 32'd1);
      check("load_rx_ready", 32'(rx_ready), 32'd1);
    end
    if (!reset && done) done_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t f;

    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    cpu_din     = 16'h0000;
    cpu_address = '0;
    cpu_rnw     = 1'b1;
    cpu_cs_b    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_loading", 32'(loading), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);

    // CPU pass-through while idle.
    cpu_set(11'h123, 16'hBEEF, 1'b0, 1'b0);
    check("cpu_wr_address", 32'(ram_address), 32'h123);
    check("cpu_wr_din", 32'(ram_din), 32'hBEEF);
    check("cpu_wr_cs_b", 32'(ram_cs_b), 32'd0);
    check("cpu_wr_rnw", 32'(ram_rnw), 32'd0);
    cpu_set(11'h7FE, 16'hBEEF, 1'b1, 1'b0);
    check("cpu_rd_rnw", 32'(ram_rnw), 32'd1);
    check("cpu_rd_address", 32'(ram_address), 32'h7FE);

    // Garbage while idle is discarded.
    send_byte(8'h00);
    check("garbage_00_idle", 32'(loading), 32'd0);
    send_byte(8'hFF);
    check("garbage_ff_idle", 32'(loading), 32'd0);
    send_byte(8'h54);
    check("garbage_54_idle", 32'(loading), 32'd0);
    rx_valid = 1'b0;

    // CPU keeps requesting writes during frames; they must be ignored.
    cpu_set(11'h123, 16'hBEEF, 1'b0, 1'b0);

    // Good frame.
    obs_q.delete();
    f = '{8'h55, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA};
    send_frame(f);
    check("good_writes", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("good_w0_addr", 32'(obs_q[0].a), 32'h010);
      check("good_w0_data", 32'(obs_q[0].d), 32'h1234);
      check("good_w1_addr", 32'(obs_q[1].a), 32'h011);
      check("good_w1_data", 32'(obs_q[1].d), 32'h5678);
    end

    // Bad checksum: writes still happen, error sticks.
    obs_q.delete();
    f = '{8'h55, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDB};
    send_frame(f);
    check("bad_writes", 32'(obs_q.size()), 32'd2);
    repeat (3) @(negedge clk);
    check("error_sticky_idle", 32'(error), 32'd1);
    send_byte(8'h00);
    rx_valid = 1'b0;
    check("error_sticky_garbage", 32'(error), 32'd1);

    // Zero count (its SYNC clears the error).
    obs_q.delete();
    f = '{8'h55, 8'h20, 8'h00, 8'h00, 8'h00, 8'hE0};
    send_frame(f);
    check("zero_cnt_writes", 32'(obs_q.size()), 32'd0);

    // Address wrap-around.
    obs_q.delete();
    f = '{8'h55, 8'hFF, 8'h07, 8'h02, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'h00};
    f.push_back(csum_of(f));
    check("wrap_csum_value", 32'(f[9]), 32'h93);
    send_frame(f);
    check("wrap_writes", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("wrap_w0_addr", 32'(obs_q[0].a), 32'h7FF);
      check("wrap_w0_data", 32'(obs_q[0].d), 32'h00AA);
      check("wrap_w1_addr", 32'(obs_q[1].a), 32'h000);
      check("wrap_w1_data", 32'(obs_q[1].d), 32'h00BB);
    end

    // Oversize count aborts after CNT_HI.
    obs_q.delete();
    f = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h08};
    send_frame(f);
    repeat (3) @(negedge clk);
    check("oversize_idle_loading", 32'(loading), 32'd0);
    check("oversize_idle_error", 32'(error), 32'd1);
    check("oversize_writes", 32'(obs_q.size()), 32'd0);

    // Reset while waiting for DATA_HI.
    obs_q.delete();
    send_byte(8'h55);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h34);
    #1;
    reset   = 1'b1;
    rx_data = 8'h12;
    @(negedge clk);
    check("midrst_loading", 32'(loading), 32'd0);
    check("midrst_ram_cs_b", 32'(ram_cs_b), 32'd1);
    @(posedge clk);
    #2;
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("after_rst_loading", 32'(loading), 32'd0);
    check("after_rst_error", 32'(error), 32'd0);
    check("after_rst_done", 32'(done), 32'd0);
    check("after_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("after_rst_writes", 32'(obs_q.size()), 32'd0);

    // Full good frame after the abandoned one.
    obs_q.delete();
    f = '{8'h55, 8'h00, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE};
    f.push_back(csum_of(f));
    send_frame(f);
    check("reload_writes", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) begin
      check("reload_addr", 32'(obs_q[0].a), 32'h100);
      check("reload_data", 32'(obs_q[0].d), 32'hBEEF);
    end

    repeat (3) @(negedge clk);
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    check("done_pulse_count", 32'(done_seen), 32'(done_exp));
    check("done_pulse_literal", 32'(done_seen), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
